// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the select of an 8:1 channel mux through
// channels 0..7, holding each for dwell+1 cycles and sampling the mux
// output on the last cycle of each slot, then presents the eight samples
// as one word on a valid/ready handshake. Single-shot or continuous.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin one scan (only honoured in IDLE)
//   continuous      chain another scan after each accepted word
//   dwell           extra settling cycles per channel (latched at start)
//   mux_o           sampled mux output
//   sel             mux select
//   word            assembled result, word[k] = sample taken with sel==k
//   word_valid      word available, held until accepted
//   word_ready      downstream accept
//   busy            a scan or its pending output is in progress
module mux_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_o,
    output logic [2:0]         sel,
    output logic [7:0]         word,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;

    logic [1:0]         state;
    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] dwell_q;
    // Channel 7 is never stored here: its sample goes straight into word.
    logic [6:0]         capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 3'd0;
            word       <= 8'd0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            count      <= '0;
            dwell_q    <= '0;
            capture    <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dwell_q <= dwell;
                        sel     <= 3'd0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    // Sample on the last cycle of the slot so the mux has
                    // had dwell_q cycles to settle after the select moved.
                    if (count == dwell_q) begin
                        count <= '0;
                        if (sel != 3'd7) begin
                            capture[sel] <= mux_o;
                            sel          <= sel + 3'd1;
                        end else begin
                            word       <= {mux_o, capture};
                            word_valid <= 1'b1;
                            state      <= OUTPUT;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        sel        <= 3'd0;
                        count      <= '0;
                        if (continuous) begin
                            // Acceptance edge doubles as the next start edge.
                            dwell_q <= dwell;
                            state   <= SCAN;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomised scoreboard bench for mux_scan_sequencer: a modelled 8:1 mux
// feeds the DUT, expected words and their arrival cycles are queued at issue.
module tb_mux_scan_sequencer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic          mux_o;
    logic [2:0]    sel;
    logic [7:0]    word;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic          busy;
    logic [7:0]    mux_in = 8'd0;

    always #5 clk = ~clk;

    assign mux_o = mux_in[sel];

    mux_scan_sequencer #(.DWELL_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .dwell      (dwell),
        .mux_o      (mux_o),
        .sel        (sel),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] w;
        int         t;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   cur_t = 0;
    int   cur_d = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: every rising word_valid must match the oldest queued scan,
    // both in value and in the edge at which it appeared.
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (word_valid && !pv) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0h expected none", word);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("word", word, e.w);
                check("latency", cyc, e.t);
            end
        end
        pv = word_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        repeat (n) step();
        rst = 1'b0;
        check("rst_sel", sel, 0);
        check("rst_word", word, 0);
        check("rst_valid", word_valid, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic begin_scan(input logic [7:0] pat, input int d);
        mux_in = pat;
        dwell = d[DW-1:0];
        start = 1'b1;
        cur_t = cyc + 1;
        cur_d = d;
        q.push_back('{pat, cur_t + 8 * (d + 1)});
        step();
        start = 1'b0;
    endtask

    // Expected select after edge T+j is j/(D+1) for the whole scan window.
    task automatic wait_word(input bit jitter);
        int lim;
        int j;
        lim = 8 * (cur_d + 1) + 4;
        for (int g = 0; g < lim && !word_valid; g++) begin
            j = cyc - cur_t;
            if (j < 8 * (cur_d + 1)) begin
                check("sel_step", sel, j / (cur_d + 1));
                check("busy_scan", busy, 1);
            end
            if (jitter) begin
                dwell = DW'($urandom);
                start = 1'($urandom_range(0, 1));
                word_ready = 1'($urandom_range(0, 1));
            end
            step();
        end
        start = 1'b0;
        check("word_valid_timeout", word_valid, 1);
        check("sel_out", sel, 7);
    endtask

    task automatic handshake(input int waits, input bit cont,
                             input logic [7:0] npat, input int nd,
                             input bit poke);
        logic [7:0] held;
        held = word;
        word_ready = 1'b0;
        repeat (waits) begin
            if (poke) start = 1'($urandom_range(0, 1));
            step();
            check("hold_valid", word_valid, 1);
            check("hold_word", word, held);
            check("hold_sel", sel, 7);
        end
        start = 1'b0;
        word_ready = 1'b1;
        continuous = cont;
        if (cont) begin
            mux_in = npat;
            dwell = nd[DW-1:0];
            cur_t = cyc + 1;
            cur_d = nd;
            q.push_back('{npat, cur_t + 8 * (nd + 1)});
        end
        step();
        word_ready = 1'b0;
        continuous = 1'b0;
        check("valid_drop", word_valid, 0);
        check("word_kept", word, held);
        check("sel_zero", sel, 0);
        check("busy_after", busy, 32'(cont));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int chain;
        int d;
        int nd;
        logic [7:0] pat;
        logic [7:0] npat;

        step();
        do_reset(2);
        repeat (3) step();
        do_reset(2);

        begin_scan(8'hA5, 0);
        wait_word(1'b0);
        handshake(0, 1'b0, 8'h00, 0, 1'b0);

        begin_scan(8'h3C, 3);
        repeat (9) step();
        dwell = 8'd0;
        wait_word(1'b0);
        handshake(0, 1'b0, 8'h00, 0, 1'b0);

        begin_scan(8'hC3, 1);
        wait_word(1'b0);
        handshake(10, 1'b0, 8'h00, 0, 1'b1);
        repeat (3) step();
        check("idle_busy", busy, 0);
        check("idle_valid", word_valid, 0);

        begin_scan(8'h01, 0);
        wait_word(1'b0);
        handshake(0, 1'b1, 8'h80, 0, 1'b0);
        wait_word(1'b0);
        handshake(0, 1'b0, 8'h00, 0, 1'b0);

        begin_scan(8'hFF, 1);
        repeat (8) step();
        check("mid_sel", sel, 4);
        do_reset(1);
        repeat (20) step();
        check("post_rst_valid", word_valid, 0);
        begin_scan(8'h5A, 0);
        wait_word(1'b0);
        handshake(1, 1'b0, 8'h00, 0, 1'b0);

        begin_scan(8'h96, 255);
        wait_word(1'b0);
        handshake(0, 1'b0, 8'h00, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            pat = 8'($urandom);
            d = $urandom_range(0, 6);
            chain = $urandom_range(1, 3);
            begin_scan(pat, d);
            wait_word(1'b1);
            for (int k = 0; k < chain; k++) begin
                npat = 8'($urandom);
                nd = $urandom_range(0, 6);
                handshake($urandom_range(0, 3), k < chain - 1, npat, nd,
                          1'b1);
                if (k < chain - 1) wait_word(1'b1);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (5) step();
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
